// File: rtl/sbox_arb_pkg.sv
// Shared encodings, default widths and helpers for the S-box BRAM arbiter.
package sbox_arb_pkg;

    localparam logic [1:0] ST_INIT  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    localparam int DEF_NUM_REQ  = 4;
    localparam int DEF_ADDR_W   = 10;
    localparam int DEF_DATA_W   = 8;
    localparam int DEF_BRAM_LAT = 2;
    localparam int DEF_INIT_CYC = 2;

    // Bits needed to index n items; never below 1 so ports stay legal for n <= 2.
    function automatic int clog2(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) w++;
        return w;
    endfunction

endpackage

// File: rtl/sbox_rr_pick2.sv
// Two-grant cyclic picker: first and second requesting index scanning from ptr.
module sbox_rr_pick2
    import sbox_arb_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int TAG_W   = clog2(DEF_NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [TAG_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] gnt_a,
    output logic [NUM_REQ-1:0] gnt_b,
    output logic               vld_a,
    output logic               vld_b,
    output logic [TAG_W-1:0]   idx_a,
    output logic [TAG_W-1:0]   idx_b
);

    always_comb begin
        gnt_a = '0;
        gnt_b = '0;
        vld_a = 1'b0;
        vld_b = 1'b0;
        idx_a = '0;
        idx_b = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            int j;
            logic [TAG_W-1:0] jj;
            j = int'(ptr) + k;
            if (j >= NUM_REQ) j = j - NUM_REQ;
            jj = TAG_W'(j);
            if (req[jj]) begin
                if (!vld_a) begin
                    vld_a = 1'b1;
                    idx_a = jj;
                end else if (!vld_b) begin
                    vld_b = 1'b1;
                    idx_b = jj;
                end
            end
        end
        gnt_a[idx_a] = vld_a;
        gnt_b[idx_b] = vld_b;
    end

endmodule

// File: rtl/sbox_bram_arbiter.sv
// Shares one dual-port S-box BRAM among NUM_REQ requesters with tagged, in-order responses.
// Define SBOX_ARB_PRIO_EN to give requester 0 fixed priority on port A.
module sbox_bram_arbiter
    import sbox_arb_pkg::*;
#(
    parameter int NUM_REQ  = DEF_NUM_REQ,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int BRAM_LAT = DEF_BRAM_LAT,
    parameter int INIT_CYC = DEF_INIT_CYC
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [NUM_REQ*DATA_W-1:0] rsp_data,
    input  logic                      flush_req,
    output logic                      flush_done,
    output logic                      busy,
    output logic [ADDR_W-1:0]         bram_addra,
    output logic [ADDR_W-1:0]         bram_addrb,
    output logic                      bram_en,
    output logic                      bram_rst,
    input  logic [DATA_W-1:0]         bram_doa,
    input  logic [DATA_W-1:0]         bram_dob
);

    localparam int TAG_W  = clog2(NUM_REQ);
    localparam int CNT_W  = clog2(2 * BRAM_LAT + 1);
    localparam int INIT_W = clog2(INIT_CYC + 1);
    localparam int LAST   = BRAM_LAT - 1;
`ifdef SBOX_ARB_PRIO_EN
    localparam logic [TAG_W-1:0] PTR_RST = TAG_W'(1);
`else
    localparam logic [TAG_W-1:0] PTR_RST = '0;
`endif

    logic [1:0]         state;
    logic [INIT_W-1:0]  init_cnt;
    logic [TAG_W-1:0]   rr_ptr, next_ptr, last_idx;
    logic               drained;
    logic               grant_en;
    logic [CNT_W-1:0]   in_flight;
    logic [NUM_REQ-1:0] pick_req, p_gnt_a, p_gnt_b, gnt_a, gnt_b, rsp_valid_nxt;
    logic               p_vld_a, p_vld_b, vld_a, vld_b;
    logic [TAG_W-1:0]   p_idx_a, p_idx_b, idx_a, idx_b;
    logic [ADDR_W-1:0]  addr_a, addr_b;
    logic               vld_a_p [BRAM_LAT];
    logic               vld_b_p [BRAM_LAT];
    logic [TAG_W-1:0]   id_a_p  [BRAM_LAT];
    logic [TAG_W-1:0]   id_b_p  [BRAM_LAT];

`ifdef SBOX_ARB_PRIO_EN
    assign pick_req = req_valid & ~NUM_REQ'(1);
`else
    assign pick_req = req_valid;
`endif

    sbox_rr_pick2 #(.NUM_REQ(NUM_REQ), .TAG_W(TAG_W)) u_pick (
        .req   (pick_req),
        .ptr   (rr_ptr),
        .gnt_a (p_gnt_a),
        .gnt_b (p_gnt_b),
        .vld_a (p_vld_a),
        .vld_b (p_vld_b),
        .idx_a (p_idx_a),
        .idx_b (p_idx_b)
    );

    always_comb begin
        gnt_a = p_gnt_a;
        gnt_b = p_gnt_b;
        vld_a = p_vld_a;
        vld_b = p_vld_b;
        idx_a = p_idx_a;
        idx_b = p_idx_b;
`ifdef SBOX_ARB_PRIO_EN
        // Requester 0 preempts port A; the round-robin winner slides to port B.
        if (req_valid[0]) begin
            gnt_a = NUM_REQ'(1);
            vld_a = 1'b1;
            idx_a = '0;
            gnt_b = p_gnt_a;
            vld_b = p_vld_a;
            idx_b = p_idx_a;
        end
`endif
    end

    assign grant_en  = (state == ST_RUN) && !flush_req;
    assign req_ready = grant_en ? (gnt_a | gnt_b) : '0;

    always_comb begin
        last_idx = vld_b ? idx_b : idx_a;
`ifdef SBOX_ARB_PRIO_EN
        if (last_idx == '0)
            next_ptr = rr_ptr;
        else if (int'(last_idx) == NUM_REQ - 1)
            next_ptr = TAG_W'(1);
        else
            next_ptr = last_idx + 1'b1;
`else
        if (int'(last_idx) == NUM_REQ - 1)
            next_ptr = '0;
        else
            next_ptr = last_idx + 1'b1;
`endif
    end

    always_comb begin
        addr_a = '0;
        addr_b = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (idx_a == TAG_W'(i)) addr_a = req_addr[i*ADDR_W +: ADDR_W];
            if (idx_b == TAG_W'(i)) addr_b = req_addr[i*ADDR_W +: ADDR_W];
        end
    end

    always_comb begin
        in_flight = '0;
        for (int i = 0; i < BRAM_LAT; i++)
            in_flight = in_flight + CNT_W'(vld_a_p[i]) + CNT_W'(vld_b_p[i]);
    end

    assign busy = (state != ST_RUN) || (in_flight != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_INIT;
            init_cnt   <= '0;
            bram_en    <= 1'b0;
            bram_rst   <= 1'b1;
            drained    <= 1'b0;
            flush_done <= 1'b0;
            rr_ptr     <= PTR_RST;
        end else begin
            bram_en    <= 1'b1;
            flush_done <= 1'b0;
            case (state)
                ST_INIT: begin
                    init_cnt <= init_cnt + 1'b1;
                    if (init_cnt == INIT_W'(INIT_CYC - 1)) begin
                        state    <= ST_RUN;
                        bram_rst <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (flush_req) begin
                        state   <= ST_DRAIN;
                        drained <= 1'b0;
                    end
                end
                ST_DRAIN: begin
                    // Pulse once per drain even if flush_req is held afterwards.
                    if (in_flight == '0) begin
                        flush_done <= !drained;
                        drained    <= 1'b1;
                        if (!flush_req) state <= ST_RUN;
                    end
                end
                default: begin
                    state    <= ST_INIT;
                    init_cnt <= '0;
                    bram_rst <= 1'b1;
                end
            endcase
            if (grant_en && vld_a) rr_ptr <= next_ptr;
        end
    end

    // Stage p0: address launch and tag entry
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bram_addra <= '0;
            bram_addrb <= '0;
            for (int i = 0; i < BRAM_LAT; i++) begin
                vld_a_p[i] <= 1'b0;
                vld_b_p[i] <= 1'b0;
                id_a_p[i]  <= '0;
                id_b_p[i]  <= '0;
            end
        end else begin
            if (grant_en && vld_a) bram_addra <= addr_a;
            if (grant_en && vld_b) bram_addrb <= addr_b;
            vld_a_p[0] <= grant_en && vld_a;
            vld_b_p[0] <= grant_en && vld_b;
            id_a_p[0]  <= idx_a;
            id_b_p[0]  <= idx_b;
            for (int i = 1; i < BRAM_LAT; i++) begin
                vld_a_p[i] <= vld_a_p[i-1];
                vld_b_p[i] <= vld_b_p[i-1];
                id_a_p[i]  <= id_a_p[i-1];
                id_b_p[i]  <= id_b_p[i-1];
            end
        end
    end

    always_comb begin
        rsp_valid_nxt = '0;
        if (vld_a_p[LAST]) rsp_valid_nxt[id_a_p[LAST]] = 1'b1;
        if (vld_b_p[LAST]) rsp_valid_nxt[id_b_p[LAST]] = 1'b1;
    end

    // Stage p2: response capture from the BRAM output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid <= '0;
            rsp_data  <= '0;
        end else begin
            rsp_valid <= rsp_valid_nxt;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (vld_a_p[LAST] && id_a_p[LAST] == TAG_W'(i))
                    rsp_data[i*DATA_W +: DATA_W] <= bram_doa;
                else if (vld_b_p[LAST] && id_b_p[LAST] == TAG_W'(i))
                    rsp_data[i*DATA_W +: DATA_W] <= bram_dob;
            end
        end
    end

endmodule

// File: tb/tb_sbox_bram_arbiter.sv
// Bench for sbox_bram_arbiter: directed scenarios plus random traffic against a queue-based model.
// Honours SBOX_ARB_PRIO_EN when the design is built with it.
module tb_sbox_bram_arbiter;
    localparam int N    = 4;
    localparam int AW   = 10;
    localparam int DW   = 8;
    localparam int LAT  = 2;
    localparam int ICYC = 2;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N-1:0]    req_valid = '0;
    logic [N*AW-1:0] req_addr = '0;
    logic            flush_req = 1'b0;
    logic [N-1:0]    req_ready, rsp_valid;
    logic [N*DW-1:0] rsp_data;
    logic            flush_done, busy, bram_en, bram_rst;
    logic [AW-1:0]   bram_addra, bram_addrb;
    logic [DW-1:0]   bram_doa = '0;
    logic [DW-1:0]   bram_dob = '0;

    int n_cmp = 0;
    int n_fail = 0;

    sbox_bram_arbiter dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_addr(req_addr),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .flush_req(flush_req), .flush_done(flush_done), .busy(busy),
        .bram_addra(bram_addra), .bram_addrb(bram_addrb), .bram_en(bram_en),
        .bram_rst(bram_rst), .bram_doa(bram_doa), .bram_dob(bram_dob)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] mem_val(input logic [AW-1:0] a);
        return a[7:0] ^ {a[9:8], 6'b0};
    endfunction

    // BRAM: address presented by the arbiter, registered output one clock later.
    always @(posedge clk) begin
        if (bram_rst) begin
            bram_doa <= '0;
            bram_dob <= '0;
        end else if (bram_en) begin
            bram_doa <= mem_val(bram_addra);
            bram_dob <= mem_val(bram_addrb);
        end
    end

    function automatic void check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Behavioural model: mode 0=init, 1=run, 2=drain; responses as a queue of due cycles.
    typedef struct { int due; int id; logic [DW-1:0] data; } rsp_t;
    rsp_t            pend[$];
    int              cyc = 0;
    int              m_mode, m_init_left, m_since_rst, m_ptr;
    bit              m_drained, m_fd;
    logic [AW-1:0]   m_addra, m_addrb;
    logic [N*DW-1:0] m_rsp_data;

    function automatic void model_reset();
        pend.delete();
        m_mode = 0;
        m_init_left = ICYC;
        m_since_rst = 0;
`ifdef SBOX_ARB_PRIO_EN
        m_ptr = 1;
`else
        m_ptr = 0;
`endif
        m_drained = 1'b0;
        m_fd = 1'b0;
        m_addra = '0;
        m_addrb = '0;
        m_rsp_data = '0;
    endfunction

    function automatic void pick(input logic [N-1:0] req, input int ptr, output int a, output int b);
        int order[$];
        int idx;
`ifdef SBOX_ARB_PRIO_EN
        if (req[0]) order.push_back(0);
        for (int k = 0; k < N - 1; k++) begin
            idx = 1 + ((ptr - 1 + k) % (N - 1));
            if (req[idx]) order.push_back(idx);
        end
`else
        for (int k = 0; k < N; k++) begin
            idx = (ptr + k) % N;
            if (req[idx]) order.push_back(idx);
        end
`endif
        a = (order.size() > 0) ? order[0] : -1;
        b = (order.size() > 1) ? order[1] : -1;
    endfunction

    always @(negedge clk) begin : cmp
        int a, b, infl, last;
        logic [N-1:0] er, ev;
        logic [AW-1:0] ad;
        rsp_t keep[$];
        if (!rst_n) model_reset();
        a = -1;
        b = -1;
        if (m_mode == 1 && !flush_req) pick(req_valid, m_ptr, a, b);
        er = '0;
        if (a >= 0) er[a] = 1'b1;
        if (b >= 0) er[b] = 1'b1;
        ev = '0;
        infl = 0;
        keep.delete();
        foreach (pend[i]) begin
            if (pend[i].due == cyc) begin
                ev[pend[i].id] = 1'b1;
                m_rsp_data[pend[i].id*DW +: DW] = pend[i].data;
            end else begin
                keep.push_back(pend[i]);
            end
            if (pend[i].due == cyc + 1 || pend[i].due == cyc + 2) infl++;
        end
        pend = keep;
        check("req_ready", req_ready, er);
        check("rsp_valid", rsp_valid, ev);
        check("rsp_data", rsp_data, m_rsp_data);
        check("flush_done", flush_done, m_fd);
        check("busy", busy, (m_mode != 1 || infl > 0));
        check("bram_addra", bram_addra, m_addra);
        check("bram_addrb", bram_addrb, m_addrb);
        check("bram_en", bram_en, (m_since_rst > 0));
        check("bram_rst", bram_rst, (m_mode == 0));
        if (rst_n) begin
            if (a >= 0) begin
                ad = req_addr[a*AW +: AW];
                pend.push_back('{cyc + 1 + LAT, a, mem_val(ad)});
                m_addra = ad;
            end
            if (b >= 0) begin
                ad = req_addr[b*AW +: AW];
                pend.push_back('{cyc + 1 + LAT, b, mem_val(ad)});
                m_addrb = ad;
            end
            if (a >= 0) begin
                last = (b >= 0) ? b : a;
`ifdef SBOX_ARB_PRIO_EN
                if (last != 0) m_ptr = (last == N - 1) ? 1 : last + 1;
`else
                m_ptr = (last + 1) % N;
`endif
            end
            m_fd = 1'b0;
            case (m_mode)
                0: begin
                    m_init_left--;
                    if (m_init_left == 0) m_mode = 1;
                end
                1: if (flush_req) begin
                    m_mode = 2;
                    m_drained = 1'b0;
                end
                default: if (infl == 0) begin
                    m_fd = !m_drained;
                    m_drained = 1'b1;
                    if (!flush_req) m_mode = 1;
                end
            endcase
            m_since_rst++;
        end
        cyc++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_addrs();
        for (int i = 0; i < N; i++) req_addr[i*AW +: AW] = AW'($urandom);
    endtask

    initial begin : stim
        int cnt, found, rv_or, cnt_rst;
        logic [N-1:0] rdy_or, exp_g;
        int tally[N];
        int exp_tally[N];

        // Reset release: bram_rst for exactly two cycles, no grants during init
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        req_valid = '1;
        cnt = 0;
        rdy_or = '0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (bram_rst) cnt++;
            if (k < 2) rdy_or |= req_ready;
            if (k == 1) req_valid = '0;
        end
        check("t1_bram_rst_cycles", cnt, 2);
        check("t1_no_grant_in_init", rdy_or, 0);
        found = 0;
        for (int k = 0; k < 10 && found == 0; k++) begin
            @(negedge clk);
            if (!busy) found = 1;
        end
        check("t1_busy_falls", found, 1);

        // Single request from requester 2, address 5
        tick();
        rand_addrs();
        req_addr[2*AW +: AW] = 10'h005;
        req_valid = 4'b0100;
        @(negedge clk);
        check("t2_ready", req_ready, 4'b0100);
        tick();
        req_valid = '0;
        @(negedge clk);
        check("t2_addra", bram_addra, 10'h005);
        check("t2_addrb_held", bram_addrb, 0);
        @(negedge clk);
        check("t2_no_early_rsp", rsp_valid, 0);
        @(negedge clk);
        check("t2_rsp_valid", rsp_valid, 4'b0100);
        check("t2_rsp_data", rsp_data[2*DW +: DW], 8'h05);

        // Requester 3 alone moves the pointer to 0, then everybody requests
        tick();
        req_valid = 4'b1000;
        tick();
        req_valid = 4'b1111;
        rand_addrs();
        for (int i = 0; i < N; i++) tally[i] = 0;
`ifdef SBOX_ARB_PRIO_EN
        exp_tally = '{8, 3, 3, 2};
`else
        exp_tally = '{4, 4, 4, 4};
`endif
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
`ifdef SBOX_ARB_PRIO_EN
            exp_g = 4'b0001 | (4'b0001 << ((k % 3) + 1));
`else
            exp_g = (k % 2 == 0) ? 4'b0011 : 4'b1100;
`endif
            check("t3_grant_pair", req_ready, exp_g);
            for (int i = 0; i < N; i++) if (req_ready[i]) tally[i]++;
            tick();
            rand_addrs();
        end
        for (int i = 0; i < N; i++) check("t3_share", tally[i], exp_tally[i]);

        // Flush with four reads in flight
        @(negedge clk);
        tick();
        rand_addrs();
        @(negedge clk);
        tick();
        flush_req = 1'b1;
        @(negedge clk);
        check("t4_no_grant", req_ready, 0);
        for (int k = 1; k <= 4; k++) begin
            tick();
            @(negedge clk);
            check("t4_flush_done", flush_done, (k == 3));
        end
        tick();
        flush_req = 1'b0;
        @(negedge clk);
        tick();
        @(negedge clk);
        check("t4_resume", $countones(req_ready), 2);

        // Reset with reads in flight
        tick();
        rand_addrs();
        @(negedge clk);
        tick();
        rst_n = 1'b0;
        req_valid = '0;
        tick();
        tick();
        rst_n = 1'b1;
        rv_or = 0;
        cnt_rst = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (rsp_valid != '0) rv_or = 1;
            if (bram_rst) cnt_rst++;
        end
        check("t5_no_rsp_after_reset", rv_or, 0);
        check("t5_reinit", cnt_rst, 2);

        // Random traffic, flushes and occasional resets
        for (int k = 0; k < 600; k++) begin
            tick();
            req_valid = N'($urandom);
            rand_addrs();
            if (!flush_req && $urandom_range(0, 31) == 0) flush_req = 1'b1;
            else if (flush_req && $urandom_range(0, 3) == 0) flush_req = 1'b0;
            if (!rst_n) rst_n = 1'b1;
            else if ($urandom_range(0, 199) == 0) rst_n = 1'b0;
        end
        tick();
        rst_n = 1'b1;
        req_valid = '0;
        flush_req = 1'b0;
        repeat (8) tick();
        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
